// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state type, arbitration modes and default widths
// Contents: arb_state_e (IDLE/BUSY/DONE), ARB_RR/ARB_FIXED mode codes,
//           ADDR_W_DEF/LINE_W_DEF default line address and line data widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam int ARB_RR     = 0;
  localparam int ARB_FIXED  = 1;

  localparam int ADDR_W_DEF = 28;
  localparam int LINE_W_DEF = 128;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - slow-memory line port shared by all cache channels
// Signals: read/write (command), addr (line address), wdata (write line),
//          rdata (read line, valid with ready), ready (one-cycle completion).
// Modports: master = arbiter side, slave = memory side.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) ();

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              ready;

  modport master (output read, output write, output addr, output wdata,
                  input rdata, input ready);

  modport slave  (input read, input write, input addr, input wdata,
                  output rdata, output ready);

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// rtl/mem_arbiter_rr_picker.sv - combinational rotating-priority request picker
// Ports: req  - per-channel request vector
//        ptr  - channel with highest priority this round
//        mode - 1 = fixed priority (channel 0 highest, ptr ignored)
//        valid/idx - some channel requests / index of the chosen channel
module rr_picker #(
  parameter int  NUM_CH = 2,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              mode,
  output logic              valid,
  output logic [CH_W-1:0]   idx
);

  // One extra bit so start + offset never overflows before the wrap.
  logic [CH_W:0]   sum;
  logic [CH_W-1:0] cand;
  logic [CH_W-1:0] start;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    start = mode ? '0 : ptr;
    // Walk offsets from farthest to nearest so the nearest requester is written last.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      sum = {1'b0, start} + (CH_W+1)'(k);
      if (sum >= (CH_W+1)'(NUM_CH)) begin
        sum = sum - (CH_W+1)'(NUM_CH);
      end
      cand = sum[CH_W-1:0];
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one slow-memory line port among NUM_CH cache miss ports
// Ports: clk, rst_n (async, active-low)
//        ch_read/ch_write/ch_addr/ch_wdata - packed per-channel line requests
//        ch_rdata (broadcast read line), ch_ready (one-hot completion pulse)
//        mem       - memory port (mem_arbiter_if.master)
//        grant_ch  - channel currently or last granted; busy - BUSY or DONE
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  NUM_CH   = 2,
  parameter int  ADDR_W   = ADDR_W_DEF,
  parameter int  LINE_W   = LINE_W_DEF,
  parameter int  ARB_MODE = ARB_RR,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
  output logic [LINE_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_ready,
  mem_arbiter_if.master            mem,
  output logic [CH_W-1:0]          grant_ch,
  output logic                     busy
);

  localparam logic FIXED = (ARB_MODE == ARB_FIXED);

  arb_state_e        state_q, state_d;
  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rdata_q;
  logic              wr_q;

  logic [NUM_CH-1:0] req;
  logic [CH_W-1:0]   pick_ptr;
  logic              pick_valid;
  logic [CH_W-1:0]   pick_idx;

  assign req      = ch_read | ch_write;
  assign pick_ptr = FIXED ? '0 : ptr_q;

  rr_picker #(.NUM_CH(NUM_CH)) u_picker (
    .req   (req),
    .ptr   (pick_ptr),
    .mode  (FIXED),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = BUSY;
      BUSY:    if (mem.ready)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction latches: captured once on IDLE->BUSY so channel inputs are
  // free to change while the memory works.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && pick_valid) begin
        grant_q <= pick_idx;
        addr_q  <= ch_addr[pick_idx*ADDR_W +: ADDR_W];
        wdata_q <= ch_wdata[pick_idx*LINE_W +: LINE_W];
        // read+write together is taken as a write
        wr_q    <= ch_write[pick_idx];
      end
      if (state_q == BUSY && mem.ready) begin
        rdata_q <= mem.rdata;
      end
      if (state_q == DONE && !FIXED) begin
        ptr_q <= (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
      end
    end
  end

  always_comb begin
    mem.read  = 1'b0;
    mem.write = 1'b0;
    ch_ready  = '0;
    busy      = 1'b0;
    case (state_q)
      BUSY: begin
        mem.read  = !wr_q;
        mem.write = wr_q;
        busy      = 1'b1;
      end
      DONE: begin
        ch_ready[grant_q] = 1'b1;
        busy              = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
  assign ch_rdata  = rdata_q;
  assign grant_ch  = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench: 2-channel round-robin and 4-channel fixed-priority arbiters
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         sel;            // 0 = drive/observe round-robin DUT, 1 = fixed-priority DUT
  logic [3:0]   rd, wr;
  logic [27:0]  addr [4];
  logic [127:0] wd [4];
  logic         mr;
  logic [127:0] mrd;
  int           checks = 0;
  int           errors = 0;
  int           model_ptr;

  // Round-robin DUT, 2 channels
  logic [1:0]   a_rd, a_wr, a_ready;
  logic [55:0]  a_addr;
  logic [255:0] a_wd;
  logic [127:0] a_rdata;
  logic [0:0]   a_grant;
  logic         a_busy;
  mem_arbiter_if #(.ADDR_W(28), .LINE_W(128)) a_mem ();
  assign a_rd          = sel ? 2'b00 : rd[1:0];
  assign a_wr          = sel ? 2'b00 : wr[1:0];
  assign a_addr        = {addr[1], addr[0]};
  assign a_wd          = {wd[1], wd[0]};
  assign a_mem.ready   = mr & !sel;
  assign a_mem.rdata   = mrd;

  mem_arbiter #(.NUM_CH(2), .ADDR_W(28), .LINE_W(128), .ARB_MODE(0)) u_dut_rr (
    .clk(clk), .rst_n(rst_n), .ch_read(a_rd), .ch_write(a_wr), .ch_addr(a_addr),
    .ch_wdata(a_wd), .ch_rdata(a_rdata), .ch_ready(a_ready), .mem(a_mem),
    .grant_ch(a_grant), .busy(a_busy)
  );

  // Fixed-priority DUT, 4 channels
  logic [3:0]   b_rd, b_wr, b_ready;
  logic [111:0] b_addr;
  logic [511:0] b_wd;
  logic [127:0] b_rdata;
  logic [1:0]   b_grant;
  logic         b_busy;
  mem_arbiter_if #(.ADDR_W(28), .LINE_W(128)) b_mem ();
  assign b_rd          = sel ? rd : 4'b0000;
  assign b_wr          = sel ? wr : 4'b0000;
  assign b_addr        = {addr[3], addr[2], addr[1], addr[0]};
  assign b_wd          = {wd[3], wd[2], wd[1], wd[0]};
  assign b_mem.ready   = mr & sel;
  assign b_mem.rdata   = mrd;

  mem_arbiter #(.NUM_CH(4), .ADDR_W(28), .LINE_W(128), .ARB_MODE(1)) u_dut_fx (
    .clk(clk), .rst_n(rst_n), .ch_read(b_rd), .ch_write(b_wr), .ch_addr(b_addr),
    .ch_wdata(b_wd), .ch_rdata(b_rdata), .ch_ready(b_ready), .mem(b_mem),
    .grant_ch(b_grant), .busy(b_busy)
  );

  // Observation of whichever DUT is selected
  logic         o_rd, o_wr, o_busy;
  logic [27:0]  o_addr;
  logic [127:0] o_wdata, o_rdata;
  logic [3:0]   o_ready;
  logic [1:0]   o_grant;
  logic [289:0] a_all;
  logic [292:0] b_all;
  assign o_rd    = sel ? b_mem.read  : a_mem.read;
  assign o_wr    = sel ? b_mem.write : a_mem.write;
  assign o_addr  = sel ? b_mem.addr  : a_mem.addr;
  assign o_wdata = sel ? b_mem.wdata : a_mem.wdata;
  assign o_rdata = sel ? b_rdata     : a_rdata;
  assign o_ready = sel ? b_ready     : {2'b00, a_ready};
  assign o_grant = sel ? b_grant     : {1'b0, a_grant};
  assign o_busy  = sel ? b_busy      : a_busy;
  assign a_all   = {a_mem.read, a_mem.write, a_mem.addr, a_mem.wdata, a_rdata, a_ready, a_grant, a_busy};
  assign b_all   = {b_mem.read, b_mem.write, b_mem.addr, b_mem.wdata, b_rdata, b_ready, b_grant, b_busy};

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference winner: round-robin = requester with the smallest forward
  // distance from ptr; fixed = lowest requesting index.
  function automatic int pick(input logic [3:0] req, input int n, input logic fixed, input int ptr);
    int best  = -1;
    int bestd = n;
    for (int i = 0; i < n; i++) begin
      if (req[i]) begin
        int d;
        d = fixed ? i : (i - ptr + n) % n;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic new_req(input int c, input bit allow_none);
    int k;
    k = $urandom_range(allow_none ? 0 : 1, 3);
    rd[c]   = (k == 1) || (k == 3);
    wr[c]   = (k >= 2);
    addr[c] = 28'($urandom);
    wd[c]   = rnd128();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rd    = '0;
    wr    = '0;
    mr    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic mem_respond(input int lat, input logic [127:0] d);
    repeat (lat) @(negedge clk);
    mr  = 1'b1;
    mrd = d;
    @(negedge clk);
    mr  = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rd  = 4'b0001;
    repeat (3) @(negedge clk);
    checks++; if (a_all !== '0) begin errors++; $display("FAIL reset_rr: got %h expected 0", a_all); end
    checks++; if (b_all !== '0) begin errors++; $display("FAIL reset_fx: got %h expected 0", b_all); end
    rd    = '0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (a_all !== '0) begin errors++; $display("FAIL reset_release: got %h expected 0", a_all); end
  endtask

  task automatic test_single_read();
    logic [127:0] pat;
    pat     = {16{8'hA5}};
    sel     = 1'b0;
    rd[1]   = 1'b1;
    addr[1] = 28'h0000123;
    wd[1]   = rnd128();
    @(negedge clk);
    checks++; if ({o_rd, o_wr} !== 2'b10) begin errors++; $display("FAIL single_cmd: got %b expected 10", {o_rd, o_wr}); end
    checks++; if (o_addr !== 28'h0000123) begin errors++; $display("FAIL single_addr: got %h expected 0000123", o_addr); end
    checks++; if (o_grant !== 2'd1) begin errors++; $display("FAIL single_grant: got %0d expected 1", o_grant); end
    repeat (4) @(negedge clk);
    checks++; if ({o_rd, o_ready} !== 5'b10000) begin errors++; $display("FAIL single_wait: got %b expected 10000", {o_rd, o_ready}); end
    mr  = 1'b1;
    mrd = pat;
    @(negedge clk);
    checks++; if ({o_ready, o_rd, o_wr} !== 6'b001000) begin errors++; $display("FAIL single_ready: got %b expected 001000", {o_ready, o_rd, o_wr}); end
    checks++; if (o_rdata !== pat) begin errors++; $display("FAIL single_rdata: got %h expected %h", o_rdata, pat); end
    mr    = 1'b0;
    mrd   = '0;
    rd[1] = 1'b0;
    @(negedge clk);
    checks++; if ({o_ready, o_busy} !== 5'b0 || o_rdata !== pat) begin errors++; $display("FAIL single_after: got ready %b busy %b rdata %h expected 0 0 %h", o_ready, o_busy, o_rdata, pat); end
  endtask

  task automatic test_rr_fairness();
    do_reset();
    sel     = 1'b0;
    rd[1:0] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (o_grant !== 2'(i % 2)) begin errors++; $display("FAIL rr_grant%0d: got %0d expected %0d", i, o_grant, i % 2); end
      mem_respond(i, rnd128());
      checks++; if (o_ready !== 4'(1 << (i % 2))) begin errors++; $display("FAIL rr_ready%0d: got %b expected %b", i, o_ready, 4'(1 << (i % 2))); end
      @(negedge clk);
      checks++; if ({o_ready, o_busy} !== 5'b0) begin errors++; $display("FAIL rr_pulse%0d: got %b expected 00000", i, {o_ready, o_busy}); end
    end
    rd = '0;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    sel     = 1'b1;
    rd[1]   = 1'b1;
    rd[3]   = 1'b1;
    addr[1] = 28'h1111111;
    addr[3] = 28'h3333333;
    @(negedge clk);
    checks++; if (o_grant !== 2'd1 || o_addr !== 28'h1111111) begin errors++; $display("FAIL fx_first: got %0d %h expected 1 1111111", o_grant, o_addr); end
    mem_respond(2, rnd128());
    checks++; if (o_ready !== 4'b0010) begin errors++; $display("FAIL fx_ready1: got %b expected 0010", o_ready); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (o_grant !== 2'd1) begin errors++; $display("FAIL fx_again: got %0d expected 1", o_grant); end
    mem_respond(0, rnd128());
    rd[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (o_grant !== 2'd3 || o_addr !== 28'h3333333) begin errors++; $display("FAIL fx_second: got %0d %h expected 3 3333333", o_grant, o_addr); end
    mem_respond(1, rnd128());
    checks++; if (o_ready !== 4'b1000) begin errors++; $display("FAIL fx_ready3: got %b expected 1000", o_ready); end
    rd = '0;
    @(negedge clk);
  endtask

  task automatic test_write_latch();
    logic [127:0] exp_d;
    exp_d   = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    do_reset();
    sel     = 1'b0;
    wr[0]   = 1'b1;
    addr[0] = 28'h0ABCDEF;
    wd[0]   = exp_d;
    @(negedge clk);
    checks++; if ({o_rd, o_wr} !== 2'b01 || o_wdata !== exp_d) begin errors++; $display("FAIL wr_cmd: got %b %h expected 01 %h", {o_rd, o_wr}, o_wdata, exp_d); end
    wd[0]   = ~exp_d;
    addr[0] = 28'h1234567;
    wr[0]   = 1'b0;
    rd[0]   = 1'b1;
    @(negedge clk);
    checks++; if ({o_rd, o_wr} !== 2'b01 || o_wdata !== exp_d || o_addr !== 28'h0ABCDEF) begin errors++; $display("FAIL wr_hold: got %b %h %h expected 01 %h 0ABCDEF", {o_rd, o_wr}, o_wdata, o_addr, exp_d); end
    mr = 1'b1;
    @(negedge clk);
    checks++; if ({o_rd, o_wr, o_ready} !== 6'b000001) begin errors++; $display("FAIL wr_drop: got %b expected 000001", {o_rd, o_wr, o_ready}); end
    mr = 1'b0;
    rd = '0;
    @(negedge clk);
  endtask

  task automatic test_conflict_noise();
    sel   = 1'b0;
    rd[0] = 1'b1;
    wr[0] = 1'b1;
    @(negedge clk);
    checks++; if ({o_rd, o_wr} !== 2'b01) begin errors++; $display("FAIL conflict_cmd: got %b expected 01", {o_rd, o_wr}); end
    mem_respond(1, rnd128());
    checks++; if (o_ready !== 4'b0001) begin errors++; $display("FAIL conflict_ready: got %b expected 0001", o_ready); end
    rd = '0;
    wr = '0;
    @(negedge clk);
    mr = 1'b1;
    @(negedge clk);
    mr = 1'b0;
    checks++; if ({o_ready, o_busy, o_rd, o_wr} !== 7'b0) begin errors++; $display("FAIL stray_ready: got %b expected 0000000", {o_ready, o_busy, o_rd, o_wr}); end
    @(negedge clk);
    checks++; if ({o_ready, o_busy} !== 5'b0) begin errors++; $display("FAIL stray_late: got %b expected 00000", {o_ready, o_busy}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sel   = 1'b0;
    rd[0] = 1'b1;
    @(negedge clk);
    mem_respond(0, rnd128());
    rd[0] = 1'b0;
    @(negedge clk);
    rd[1]   = 1'b1;
    addr[1] = 28'h0FEDCBA;
    @(negedge clk);
    checks++; if (o_grant !== 2'd1 || o_busy !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %0d %b expected 1 1", o_grant, o_busy); end
    #2;
    rst_n = 1'b0;
    mr    = 1'b1;
    #1;
    checks++; if (a_all !== '0) begin errors++; $display("FAIL midrst_outputs: got %h expected 0", a_all); end
    @(negedge clk);
    checks++; if (a_ready !== 2'b00) begin errors++; $display("FAIL midrst_noready: got %b expected 00", a_ready); end
    mr      = 1'b0;
    rst_n   = 1'b1;
    rd[1:0] = 2'b11;
    @(negedge clk);
    checks++; if (o_grant !== 2'd0 || o_busy !== 1'b1) begin errors++; $display("FAIL midrst_tie: got %0d %b expected 0 1", o_grant, o_busy); end
    mem_respond(0, rnd128());
    checks++; if (o_ready !== 4'b0001) begin errors++; $display("FAIL midrst_ready: got %b expected 0001", o_ready); end
    rd = '0;
    @(negedge clk);
  endtask

  task automatic test_random(input logic s, input int iters);
    int           n, w, lat;
    logic         exp_wr;
    logic [27:0]  exp_a;
    logic [127:0] exp_d, d;
    logic [3:0]   req;
    n = s ? 4 : 2;
    do_reset();
    sel       = s;
    model_ptr = 0;
    for (int it = 0; it < iters; it++) begin
      for (int c = 0; c < n; c++) begin
        if (!(rd[c] | wr[c]) && $urandom_range(0, 1) == 1) new_req(c, 1'b1);
      end
      req = (rd | wr) & 4'((1 << n) - 1);
      if (req == 4'b0) begin
        w = $urandom_range(0, n - 1);
        new_req(w, 1'b0);
        req = (rd | wr) & 4'((1 << n) - 1);
      end
      w      = pick(req, n, s, model_ptr);
      exp_wr = wr[w];
      exp_a  = addr[w];
      exp_d  = wd[w];
      @(negedge clk);
      checks++; if ({o_rd, o_wr, o_grant, o_busy} !== {!exp_wr, exp_wr, 2'(w), 1'b1}) begin errors++; $display("FAIL rand_grant it%0d: got %b expected %b", it, {o_rd, o_wr, o_grant, o_busy}, {!exp_wr, exp_wr, 2'(w), 1'b1}); end
      checks++; if ({o_addr, o_wdata} !== {exp_a, exp_d}) begin errors++; $display("FAIL rand_payload it%0d: got %h expected %h", it, {o_addr, o_wdata}, {exp_a, exp_d}); end
      lat = $urandom_range(0, 3);
      for (int j = 0; j < lat; j++) begin
        addr[w] = 28'($urandom);
        wd[w]   = rnd128();
        rd[w]   = 1'($urandom);
        wr[w]   = 1'($urandom);
        @(negedge clk);
        checks++; if ({o_rd, o_wr, o_addr, o_wdata, o_ready} !== {!exp_wr, exp_wr, exp_a, exp_d, 4'b0}) begin errors++; $display("FAIL rand_hold it%0d: got %h expected %h", it, {o_rd, o_wr, o_addr, o_wdata, o_ready}, {!exp_wr, exp_wr, exp_a, exp_d, 4'b0}); end
      end
      d   = rnd128();
      mrd = d;
      mr  = 1'b1;
      @(negedge clk);
      checks++; if ({o_ready, o_rdata, o_rd, o_wr} !== {4'(1 << w), d, 2'b00}) begin errors++; $display("FAIL rand_done it%0d: got %h expected %h", it, {o_ready, o_rdata, o_rd, o_wr}, {4'(1 << w), d, 2'b00}); end
      mr  = 1'b0;
      mrd = rnd128();
      if (!s) model_ptr = (w + 1) % n;
      new_req(w, 1'b1);
      @(negedge clk);
      checks++; if ({o_ready, o_busy, o_rdata} !== {4'b0, 1'b0, d}) begin errors++; $display("FAIL rand_idle it%0d: got %h expected %h", it, {o_ready, o_busy, o_rdata}, {4'b0, 1'b0, d}); end
    end
    rd = '0;
    wr = '0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    sel       = 1'b0;
    rd        = '0;
    wr        = '0;
    mr        = 1'b0;
    mrd       = '0;
    model_ptr = 0;
    for (int i = 0; i < 4; i++) begin
      addr[i] = '0;
      wd[i]   = '0;
    end
    test_reset();
    test_single_read();
    test_rr_fairness();
    test_fixed_priority();
    test_write_latch();
    test_conflict_noise();
    test_reset_mid();
    test_random(1'b0, 40);
    test_random(1'b1, 40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
